vx_mem_responder: RTL

VX_MEM_RESPONDER -- requirements
Module: VX_mem_responder

---
 rtl/vx_gpu_pkg.sv | 25 ++
 rtl/vx_fifo_queue.sv | 51 +++++
 rtl/vx_shift_register.sv | 39 +++
 rtl/vx_mem_responder.sv | 138 +++++++++++++
 4 files changed

// File: rtl/vx_gpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vx_gpu_pkg
// Brief    : shared line type, perf-counter struct and sizing helper
// Revision : 1.0
// ----------------------------------------------------------------------------
package vx_gpu_pkg;

  localparam int c_line_bytes = 64;

  typedef logic [8*c_line_bytes-1:0] line_t;

  typedef struct packed {
    logic [31:0] reads;
    logic [31:0] writes;
    logic [31:0] stalls;
  } perf_t;

  // Index width that never collapses to zero for single-entry structures
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_fifo_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vx_fifo_queue
// Brief    : power-of-two FIFO, head presented from storage, async active-low reset
// Revision : 1.0
// ----------------------------------------------------------------------------
module vx_fifo_queue
  import vx_gpu_pkg::*;
#(
  parameter int DATAW = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [DATAW-1:0] i_data,
  input  logic             i_pop,
  output logic [DATAW-1:0] o_data,
  output logic             o_empty
);

  localparam int c_aw = clog2_min1(DEPTH);

  logic [DATAW-1:0] r_data [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;

  // Storage is not reset; only the occupancy state is
  always_ff @(posedge clk) begin
    if (i_push) r_data[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      if (i_push && !i_pop)      r_count <= r_count + (c_aw+1)'(1);
      else if (!i_push && i_pop) r_count <= r_count - (c_aw+1)'(1);
    end
  end

  assign o_data  = r_data[r_rd_ptr];
  assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/vx_shift_register.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vx_shift_register
// Brief    : DEPTH-stage register chain with async active-low reset; DEPTH=0 is a wire
// Revision : 1.0
// ----------------------------------------------------------------------------
module vx_shift_register #(
  parameter int DATAW = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DATAW-1:0] i_data,
  output logic [DATAW-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused_ctrl;
      assign w_unused_ctrl = clk ^ reset;
      assign o_data = i_data;
    end else begin : g_pipe
      logic [DATAW-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vx_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vx_mem_responder
// Brief    : line-based memory model with fixed read latency and bounded response queue;
//            optional perf counters when VX_MEM_RESPONDER_PERF_EN is defined
// Revision : 1.0
// ----------------------------------------------------------------------------
module vx_mem_responder
  import vx_gpu_pkg::*;
#(
  parameter int LINE_SIZE      = c_line_bytes,
  parameter int ADDR_WIDTH     = 26,
  parameter int NUM_LINES      = 1024,
  parameter int TAG_WIDTH      = 8,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef VX_MEM_RESPONDER_PERF_EN
  output logic [31:0]            perf_reads,
  output logic [31:0]            perf_writes,
  output logic [31:0]            perf_stalls,
`endif
  input  logic                   mem_req_valid,
  input  logic                   mem_req_rw,
  input  logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic [LINE_SIZE-1:0]   mem_req_byteen,
  input  logic [8*LINE_SIZE-1:0] mem_req_data,
  input  logic [TAG_WIDTH-1:0]   mem_req_tag,
  output logic                   mem_req_ready,
  output logic                   mem_rsp_valid,
  output logic [8*LINE_SIZE-1:0] mem_rsp_data,
  output logic [TAG_WIDTH-1:0]   mem_rsp_tag,
  input  logic                   mem_rsp_ready
);

  localparam int c_data_w = 8*LINE_SIZE;
  localparam int c_idx_w  = clog2_min1(NUM_LINES);
  localparam int c_cnt_w  = $clog2(RSP_QUEUE_SIZE) + 1;
  localparam int c_q_w    = TAG_WIDTH + c_data_w;
  localparam int c_pipe_w = 1 + c_q_w;

  logic [c_data_w-1:0] r_mem [NUM_LINES];
  logic [c_cnt_w-1:0]  r_pending;
  logic [c_idx_w-1:0]  w_idx;
  logic                w_ready;
  logic                w_rd_fire;
  logic                w_wr_fire;
  logic                w_rsp_fire;
  logic                w_q_empty;
  logic [c_pipe_w-1:0] w_pipe_in;
  logic [c_pipe_w-1:0] w_pipe_out;
  logic [c_q_w-1:0]    w_q_out;

  assign w_idx = mem_req_addr[c_idx_w-1:0];

  generate
    if (ADDR_WIDTH > c_idx_w) begin : g_addr_alias
      logic w_unused_addr;
      assign w_unused_addr = ^mem_req_addr[ADDR_WIDTH-1:c_idx_w];
    end
  endgenerate

  // Gating with reset keeps ready low the instant reset asserts
  assign w_ready    = reset && (r_pending < c_cnt_w'(RSP_QUEUE_SIZE));
  assign w_rd_fire  = mem_req_valid && w_ready && !mem_req_rw;
  assign w_wr_fire  = mem_req_valid && w_ready &&  mem_req_rw;
  assign w_rsp_fire = mem_rsp_valid && mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int b = 0; b < LINE_SIZE; b++) begin
        if (mem_req_byteen[b]) r_mem[w_idx][8*b +: 8] <= mem_req_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else if (w_rd_fire && !w_rsp_fire) begin
      r_pending <= r_pending + c_cnt_w'(1);
    end else if (!w_rd_fire && w_rsp_fire) begin
      r_pending <= r_pending - c_cnt_w'(1);
    end
  end

  // The queue's own register supplies the last latency stage
  assign w_pipe_in = {w_rd_fire, mem_req_tag, r_mem[w_idx]};

  vx_shift_register #(
    .DATAW (c_pipe_w),
    .DEPTH (LATENCY - 1)
  ) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_data (w_pipe_in),
    .o_data (w_pipe_out)
  );

  vx_fifo_queue #(
    .DATAW (c_q_w),
    .DEPTH (RSP_QUEUE_SIZE)
  ) u_rsp_q (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_pipe_out[c_pipe_w-1]),
    .i_data  (w_pipe_out[c_q_w-1:0]),
    .i_pop   (w_rsp_fire),
    .o_data  (w_q_out),
    .o_empty (w_q_empty)
  );

  assign mem_req_ready = w_ready;
  assign mem_rsp_valid = !w_q_empty;
  assign {mem_rsp_tag, mem_rsp_data} = w_q_out;

`ifdef VX_MEM_RESPONDER_PERF_EN
  perf_t r_perf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf <= '0;
    end else begin
      if (w_rd_fire) r_perf.reads <= r_perf.reads + 32'd1;
      if (w_wr_fire) r_perf.writes <= r_perf.writes + 32'd1;
      if (mem_req_valid && !w_ready) r_perf.stalls <= r_perf.stalls + 32'd1;
    end
  end

  assign perf_reads  = r_perf.reads;
  assign perf_writes = r_perf.writes;
  assign perf_stalls = r_perf.stalls;
`endif

endmodule
`default_nettype wire
